// File: rtl/tsip_timing_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : tsip_timing_parser_if
// Description : Byte-stream input and decoded timing outputs of the TSIP
//               primary-timing-packet parser.
// Revision    : 1.0  initial release
// ============================================================================
interface tsip_timing_parser_if;
    logic [7:0]  i_rx_byte;
    logic        i_rx_dv;
    logic        o_packet_dv;
    logic [15:0] o_year;
    logic [7:0]  o_month;
    logic [7:0]  o_day;
    logic [7:0]  o_hour;
    logic [7:0]  o_minutes;
    logic [7:0]  o_seconds;
    logic [15:0] o_utc_offset;
    logic [7:0]  o_timing_flags;
    logic [7:0]  o_err_count;

    // Byte source side (UART receiver / testbench)
    modport master (
        output i_rx_byte, i_rx_dv,
        input  o_packet_dv, o_year, o_month, o_day, o_hour, o_minutes,
               o_seconds, o_utc_offset, o_timing_flags, o_err_count
    );

    // Parser side
    modport slave (
        input  i_rx_byte, i_rx_dv,
        output o_packet_dv, o_year, o_month, o_day, o_hour, o_minutes,
               o_seconds, o_utc_offset, o_timing_flags, o_err_count
    );
endinterface
`default_nettype wire

// File: rtl/tsip_timing_parser.sv
`default_nettype none
// ============================================================================
// Module      : tsip_timing_parser
// Description : Parses the Thunderbolt TSIP byte stream, extracts the 8F-AB
//               primary timing packet and presents UTC time with a one-cycle
//               valid strobe. Counts framing errors (saturating).
// Revision    : 1.0  initial release
// ============================================================================
module tsip_timing_parser #(
    parameter int unsigned TIMEOUT_CLKS = 100000
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    tsip_timing_parser_if.slave bus
);
    localparam logic [7:0]  DLE        = 8'h10;
    localparam logic [7:0]  ETX        = 8'h03;
    localparam logic [7:0]  ID_TIMING  = 8'h8F;
    localparam logic [7:0]  SUB_TIMING = 8'hAB;
    localparam logic [4:0]  PKT_LEN    = 5'd17;
    localparam logic [23:0] TO_LAST    = 24'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GOT_DLE  = 3'd1,
        S_SUB      = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_DLE = 3'd4,
        S_SKIP     = 3'd5,
        S_SKIP_DLE = 3'd6
    } state_t;

    state_t      state;
    logic [4:0]  idx;          // destuffed payload index, subcode = 0
    logic [23:0] tcnt;         // idle clocks since last byte inside a frame
    logic [7:0]  shadow [0:15];// payload indices 1..16 live at slot index-1
    logic [3:0]  slot;
    logic        timeout;
    logic        err_evt;

    assign slot    = idx[3:0] - 4'd1;
    assign timeout = !bus.i_rx_dv && (state != S_IDLE) && (tcnt == TO_LAST);

    // Decode of a packet ID byte following a DLE (DLE/ETX handled by caller)
    function automatic state_t id_next(input logic [7:0] b);
        return (b == ID_TIMING) ? S_SUB : S_SKIP;
    endfunction

    // Single error event per cycle: overflow, bad frame length, bad DLE pair, stall
    always_comb begin
        err_evt = 1'b0;
        if (bus.i_rx_dv) begin
            case (state)
                S_DATA:     err_evt = (bus.i_rx_byte != DLE) && (idx >= PKT_LEN);
                S_DATA_DLE: begin
                    if (bus.i_rx_byte == DLE)      err_evt = (idx >= PKT_LEN);
                    else if (bus.i_rx_byte == ETX) err_evt = (idx != PKT_LEN);
                    else                           err_evt = 1'b1;
                end
                default:    err_evt = 1'b0;
            endcase
        end else if (timeout) begin
            err_evt = (state == S_SUB) || (state == S_DATA) || (state == S_DATA_DLE);
        end
    end

    // Frame FSM, shadow buffer, timeout counter and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= S_IDLE;
            idx                <= 5'd0;
            tcnt               <= 24'd0;
            for (int i = 0; i < 16; i++) shadow[i] <= 8'd0;
            bus.o_packet_dv    <= 1'b0;
            bus.o_year         <= 16'd0;
            bus.o_month        <= 8'd0;
            bus.o_day          <= 8'd0;
            bus.o_hour         <= 8'd0;
            bus.o_minutes      <= 8'd0;
            bus.o_seconds      <= 8'd0;
            bus.o_utc_offset   <= 16'd0;
            bus.o_timing_flags <= 8'd0;
            bus.o_err_count    <= 8'd0;
        end else begin
            bus.o_packet_dv <= 1'b0;
            if (err_evt && (bus.o_err_count != 8'hFF))
                bus.o_err_count <= bus.o_err_count + 8'd1;

            if (bus.i_rx_dv) begin
                tcnt <= 24'd0;
                case (state)
                    S_IDLE: begin
                        if (bus.i_rx_byte == DLE) state <= S_GOT_DLE;
                    end
                    S_GOT_DLE: begin
                        if (bus.i_rx_byte == DLE || bus.i_rx_byte == ETX) state <= S_IDLE;
                        else                                             state <= id_next(bus.i_rx_byte);
                    end
                    S_SUB: begin
                        if (bus.i_rx_byte == SUB_TIMING) begin
                            state <= S_DATA;
                            idx   <= 5'd1;
                        end else if (bus.i_rx_byte == DLE) begin
                            state <= S_SKIP_DLE;
                        end else begin
                            state <= S_SKIP;
                        end
                    end
                    S_DATA: begin
                        if (bus.i_rx_byte == DLE) begin
                            state <= S_DATA_DLE;
                        end else if (idx >= PKT_LEN) begin
                            state <= S_SKIP;
                            idx   <= 5'd0;
                        end else begin
                            shadow[slot] <= bus.i_rx_byte;
                            idx          <= idx + 5'd1;
                        end
                    end
                    S_DATA_DLE: begin
                        if (bus.i_rx_byte == DLE) begin
                            if (idx >= PKT_LEN) begin
                                state <= S_SKIP;
                                idx   <= 5'd0;
                            end else begin
                                shadow[slot] <= DLE;
                                idx          <= idx + 5'd1;
                                state        <= S_DATA;
                            end
                        end else if (bus.i_rx_byte == ETX) begin
                            if (idx == PKT_LEN) begin
                                bus.o_packet_dv    <= 1'b1;
                                bus.o_year         <= {shadow[14], shadow[15]};
                                bus.o_month        <= shadow[13];
                                bus.o_day          <= shadow[12];
                                bus.o_hour         <= shadow[11];
                                bus.o_minutes      <= shadow[10];
                                bus.o_seconds      <= shadow[9];
                                bus.o_timing_flags <= shadow[8];
                                bus.o_utc_offset   <= {shadow[6], shadow[7]};
                            end
                            state <= S_IDLE;
                            idx   <= 5'd0;
                        end else begin
                            state <= id_next(bus.i_rx_byte);
                            idx   <= 5'd0;
                        end
                    end
                    S_SKIP: begin
                        if (bus.i_rx_byte == DLE) state <= S_SKIP_DLE;
                    end
                    S_SKIP_DLE: begin
                        if (bus.i_rx_byte == DLE)      state <= S_SKIP;
                        else if (bus.i_rx_byte == ETX) state <= S_IDLE;
                        else                           state <= id_next(bus.i_rx_byte);
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (timeout) begin
                    state <= S_IDLE;
                    idx   <= 5'd0;
                    tcnt  <= 24'd0;
                end else begin
                    tcnt <= tcnt + 24'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tsip_timing_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_tsip_timing_parser
// Description : Scoreboard bench for tsip_timing_parser. Directed TSIP frames
//               with hand-chosen time fields; a monitor pops expectations on
//               every o_packet_dv strobe.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tsip_timing_parser;
    localparam int unsigned TIMEOUT = 300;

    typedef struct {
        logic [15:0] year;
        logic [7:0]  month, day, hour, minutes, seconds;
        logic [15:0] offset;
        logic [7:0]  flags;
        int          cyc;
    } exp_t;
    typedef logic [7:0] pl_t [0:17];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t last;
    exp_t m_e;
    exp_t zero_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tsip_timing_parser_if bus();

    tsip_timing_parser #(.TIMEOUT_CLKS(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        chk({tag, "_year"},    32'(bus.o_year),         32'(e.year));
        chk({tag, "_month"},   32'(bus.o_month),        32'(e.month));
        chk({tag, "_day"},     32'(bus.o_day),          32'(e.day));
        chk({tag, "_hour"},    32'(bus.o_hour),         32'(e.hour));
        chk({tag, "_minutes"}, 32'(bus.o_minutes),      32'(e.minutes));
        chk({tag, "_seconds"}, 32'(bus.o_seconds),      32'(e.seconds));
        chk({tag, "_offset"},  32'(bus.o_utc_offset),   32'(e.offset));
        chk({tag, "_flags"},   32'(bus.o_timing_flags), 32'(e.flags));
    endtask

    // Monitor: every strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (bus.o_packet_dv === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_dv: o_packet_dv=1 at cycle %0d, required 0", cyc);
            end else begin
                m_e = sb_q.pop_front();
                check_fields("commit", m_e);
                chk("dv_latency", 32'(cyc), 32'(m_e.cyc));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit push, input exp_t e);
        exp_t x;
        @(negedge clk);
        if (push) begin
            x     = e;
            x.cyc = cyc + 1;
            sb_q.push_back(x);
            last  = e;
        end
        bus.i_rx_byte = b;
        bus.i_rx_dv   = 1'b1;
        if (gap > 1) begin
            @(negedge clk);
            bus.i_rx_dv = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    task automatic sb(input logic [7:0] b, input int gap);
        send_byte(b, gap, 1'b0, zero_e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.i_rx_dv = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    function automatic pl_t make_pl(input exp_t e);
        pl_t p;
        p[0] = 8'hAB;
        for (int i = 1; i <= 6; i++) p[i] = 8'h20 + 8'(i);
        p[7]  = e.offset[15:8];
        p[8]  = e.offset[7:0];
        p[9]  = e.flags;
        p[10] = e.seconds;
        p[11] = e.minutes;
        p[12] = e.hour;
        p[13] = e.day;
        p[14] = e.month;
        p[15] = e.year[15:8];
        p[16] = e.year[7:0];
        p[17] = 8'h5A;
        return p;
    endfunction

    // Frame = DLE 8F <stuffed payload[0..n-1]> DLE ETX
    task automatic send_frame(input exp_t e, input int n, input int gap, input bit expect_dv);
        pl_t p;
        p = make_pl(e);
        sb(8'h10, gap);
        sb(8'h8F, gap);
        for (int i = 0; i < n; i++) begin
            sb(p[i], gap);
            if (p[i] == 8'h10) sb(8'h10, gap);
        end
        sb(8'h10, gap);
        send_byte(8'h03, gap, expect_dv, e);
        idle(4);
    endtask

    exp_t ea, eb, ec, ed, ee;
    pl_t  pp;

    initial begin
        zero_e = '{default: 0};
        ea = '{year:16'h07E8, month:8'd3,  day:8'd15, hour:8'd12, minutes:8'd34, seconds:8'd56,
               offset:16'h0012, flags:8'h03, cyc:0};
        eb = ea;
        eb.seconds = 8'h10;
        ec = '{year:16'h07E9, month:8'd12, day:8'd31, hour:8'd23, minutes:8'd59, seconds:8'd58,
               offset:16'h0012, flags:8'h05, cyc:0};
        ed = '{year:16'h07EA, month:8'd1,  day:8'd2,  hour:8'd3,  minutes:8'd4,  seconds:8'd5,
               offset:16'h0013, flags:8'h07, cyc:0};
        ee = '{year:16'h07EB, month:8'd6,  day:8'd7,  hour:8'd8,  minutes:8'd9,  seconds:8'd10,
               offset:16'h0012, flags:8'h00, cyc:0};

        bus.i_rx_byte = 8'h00;
        bus.i_rx_dv   = 1'b0;
        repeat (3) @(negedge clk);
        check_fields("reset", zero_e);
        chk("reset_err", 32'(bus.o_err_count), 32'd0);
        chk("reset_dv",  32'(bus.o_packet_dv), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Valid packet, slow byte spacing
        send_frame(ea, 17, 100, 1'b1);
        chk("err_after_valid", 32'(bus.o_err_count), 32'd0);

        // Seconds = 0x10 stuffed, back-to-back bytes
        send_frame(eb, 17, 1, 1'b1);
        chk("err_after_stuffed", 32'(bus.o_err_count), 32'd0);

        // Foreign packet with stuffed DLE, then valid packet
        foreach (pp[i]) pp[i] = 8'h00;
        sb(8'h10, 1); sb(8'h8F, 1); sb(8'hAC, 1); sb(8'h01, 1);
        sb(8'h10, 1); sb(8'h10, 1); sb(8'h02, 1); sb(8'h10, 1); sb(8'h03, 1);
        idle(3);
        chk("err_after_foreign", 32'(bus.o_err_count), 32'd0);
        send_frame(ec, 17, 2, 1'b1);
        chk("err_after_foreign_valid", 32'(bus.o_err_count), 32'd0);

        // Truncated (15 payload bytes), then overflow (18 payload bytes)
        send_frame(ed, 15, 1, 1'b0);
        chk("err_truncated", 32'(bus.o_err_count), 32'd1);
        check_fields("hold_trunc", ec);
        send_frame(ed, 18, 1, 1'b0);
        chk("err_overflow", 32'(bus.o_err_count), 32'd2);
        check_fields("hold_ovf", ec);

        // Stall after payload byte 5, then a valid packet
        pp = make_pl(ed);
        sb(8'h10, 1); sb(8'h8F, 1);
        for (int i = 0; i <= 5; i++) sb(pp[i], 1);
        idle(TIMEOUT + 10);
        chk("err_timeout", 32'(bus.o_err_count), 32'd3);
        check_fields("hold_timeout", ec);
        send_frame(ed, 17, 3, 1'b1);
        chk("err_after_timeout_valid", 32'(bus.o_err_count), 32'd3);

        // Reset mid-packet at payload byte 8
        pp = make_pl(ee);
        sb(8'h10, 1); sb(8'h8F, 1);
        for (int i = 0; i <= 8; i++) sb(pp[i], 1);
        #2;
        rst_n = 1'b0;
        bus.i_rx_dv = 1'b0;
        #1;
        check_fields("async_rst", zero_e);
        chk("async_rst_err", 32'(bus.o_err_count), 32'd0);
        chk("async_rst_dv",  32'(bus.o_packet_dv), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_frame(ee, 17, 1, 1'b1);
        chk("err_after_reset_valid", 32'(bus.o_err_count), 32'd0);

        idle(10);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tsip_timing_parser.md
Name: tsip_timing_parser

Overview:
- Upstream stage of the pulse generator. Parses the Trimble Thunderbolt TSIP byte stream coming out of the UART receiver.
- Extracts the Primary Timing Packet (ID 0x8F, sub-ID 0xAB) and presents UTC time of day with a one-cycle data-valid strobe.
- Those outputs drive the pulse generator's thunder_* compare inputs and its packet_dv flag.
- Handles DLE byte-stuffing, foreign packets, malformed frames and line stalls. Counts errors for status readback.

Parameters:
TIMEOUT_CLKS, 100000, idle clocks allowed between bytes inside a packet before the frame is abandoned (10 ms at 10 MHz); must be < 2^24

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_byte  input  8  received UART byte
i_rx_dv  input  1  one-cycle strobe, i_rx_byte valid
o_packet_dv  output  1  one-cycle strobe, time outputs just updated from a good 8F-AB packet
o_year  output  16  UTC year (big-endian payload bytes 15..16)
o_month  output  8  payload byte 14
o_day  output  8  payload byte 13
o_hour  output  8  payload byte 12
o_minutes  output  8  payload byte 11
o_seconds  output  8  payload byte 10
o_utc_offset  output  16  payload bytes 7..8, big-endian
o_timing_flags  output  8  payload byte 9
o_err_count  output  8  saturating framing-error counter

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0:
  - all outputs = 0;
  - state = IDLE;
  - payload index = 0;
  - timeout counter = 0.
- Payload index numbering: subcode byte is index 0; a complete packet has 17 payload bytes (indices 0..16) after destuffing.
- FSM advances only on cycles with i_rx_dv=1, except for the timeout.
- IDLE: 0x10 -> GOT_DLE; other bytes ignored.
- GOT_DLE: 0x8F -> SUB; 0x10 or 0x03 -> IDLE; any other byte -> SKIP (foreign packet).
- SUB: 0xAB -> DATA with index=1 (subcode counts as index 0); 0x10 -> SKIP_DLE; other -> SKIP.
- DATA:
  - 0x10 -> DATA_DLE;
  - other -> store byte in shadow buffer at index, index+1;
  - a store at index 17 or above is an overflow: err+1, -> SKIP.
- DATA_DLE:
  - 0x10 -> store literal 0x10 (same overflow rule), -> DATA;
  - 0x03 -> end of frame: if index==17, commit, else err+1; then -> IDLE;
  - other byte -> err+1, treat as a new packet ID (same decode as GOT_DLE).
- SKIP: 0x10 -> SKIP_DLE; other bytes stay in SKIP.
- SKIP_DLE:
  - 0x10 -> SKIP;
  - 0x03 -> IDLE;
  - other -> treat as a new packet ID (as GOT_DLE); no error is counted.
- Commit:
  - all time, offset and flag outputs load from the shadow buffer on the same clock edge;
  - o_packet_dv=1 for exactly that one cycle;
  - latency = 1 clock after the i_rx_dv cycle that carried 0x03.
- Time, offset and flag outputs are never partially updated. They hold their last committed value between packets and after errors.
- No range checking of field values; the fields are passed through raw.
- Timeout:
  - in any state other than IDLE, the counter increments on each cycle with i_rx_dv=0 and clears on each i_rx_dv=1;
  - reaching TIMEOUT_CLKS -> IDLE, index=0, counter=0;
  - err+1 only if the state was SUB, DATA or DATA_DLE (a stall while skipping a foreign packet is not an error).
- o_err_count saturates at 255. At most one increment per cycle; simultaneous error conditions count once.
- Reset asserted mid-packet: the frame is discarded and outputs are cleared. The next complete packet after reset release is accepted normally.
- Throughput: accepts back-to-back bytes on consecutive cycles (i_rx_dv high every clock).

Test Plan:
- Valid packet, payload year=0x07E8, month 3, day 15, 12:34:56, flags 0x03, offset 0x0012, bytes spaced 100 clks -> o_packet_dv high exactly 1 cycle after ETX; outputs 2024/3/15 12:34:56, flags 0x03, offset 18; o_err_count 0.
- Same packet with seconds=0x10 sent stuffed as 10 10, sent back-to-back on consecutive cycles -> o_seconds=16, one dv pulse, no error.
- Foreign packet 10 8F AC … containing stuffed 10 10, terminated 10 03, followed by a valid 8F-AB packet -> no dv for the first; dv with correct fields for the second; err 0.
- Truncated 8F-AB with 15 payload bytes then 10 03 -> no dv; outputs unchanged; err 1. Then an 18-byte payload (overflow) -> err 2, no dv.
- Stall of TIMEOUT_CLKS cycles after payload byte 5, then a complete valid packet -> err +1; second packet commits correctly.
- Drop i_rst_n for 3 cycles at payload byte 8 -> all outputs 0 asynchronously, no dv. Next full packet -> dv and correct values.
